// File: rtl/mem_access_unit.sv
// Load/store front-end between EX/MEM and a word-wide synchronous-read data RAM.
// Sub-word stores use read-modify-write. Define MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_access_unit #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned RAM_IDX_LSB = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              load_valid,
   output logic [31:0]       load_data,
   output logic              access_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {StIdle, StLoadWait, StRmwWait} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [15:0]       wdata_q;
   logic [31:0]       load_data_q;
   logic              load_valid_q;
   logic              access_err_q;

   logic              accept, is_bad, misalign;
   logic              do_load, do_word_st, do_sub_st;
   logic [ADDR_W-1:0] eff_addr;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_ext, merged;

   // Request decode; misaligned addresses are force-aligned unless trapping is enabled.
   always_comb begin
      misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign = (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`endif
      eff_addr = req_addr;
      if (req_size == 2'd1) begin
         eff_addr[0] = 1'b0;
      end else if (req_size == 2'd2) begin
         eff_addr[1:0] = 2'b00;
      end
      accept     = reset && (state_q == StIdle) && req_valid;
      is_bad     = (req_read && req_write) ||
                   ((req_read || req_write) && (req_size == 2'd3 || misalign));
      do_load    = accept && req_read && !is_bad;
      do_word_st = accept && req_write && !is_bad && (req_size == 2'd2);
      do_sub_st  = accept && req_write && !is_bad && (req_size != 2'd2);
   end

   // Lane extraction for loads and lane merge for RMW stores.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    lane_b = mem_rdata[7:0];
         2'd1:    lane_b = mem_rdata[15:8];
         2'd2:    lane_b = mem_rdata[23:16];
         default: lane_b = mem_rdata[31:24];
      endcase
      lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'd0:    load_ext = {{24{~unsigned_q & lane_b[7]}}, lane_b};
         2'd1:    load_ext = {{16{~unsigned_q & lane_h[15]}}, lane_h};
         default: load_ext = mem_rdata;
      endcase
      merged = mem_rdata;
      if (size_q == 2'd0) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         StIdle: begin
            if (do_load || do_sub_st) begin
               mem_read = 1'b1;
               mem_addr = (eff_addr >> RAM_IDX_LSB) << RAM_IDX_LSB;
            end else if (do_word_st) begin
               mem_write = 1'b1;
               mem_addr  = (eff_addr >> RAM_IDX_LSB) << RAM_IDX_LSB;
               mem_wdata = req_wdata;
            end
         end
         StRmwWait: begin
            mem_write = reset;
            mem_addr  = (addr_q >> RAM_IDX_LSB) << RAM_IDX_LSB;
            mem_wdata = merged;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         size_q       <= 2'd0;
         unsigned_q   <= 1'b0;
         wdata_q      <= 16'h0;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         access_err_q <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         access_err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               access_err_q <= accept && is_bad;
               if (do_load || do_sub_st) begin
                  addr_q     <= eff_addr;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  wdata_q    <= req_wdata[15:0];
                  state_q    <= do_load ? StLoadWait : StRmwWait;
               end
            end
            StLoadWait: begin
               load_data_q  <= load_ext;
               load_valid_q <= 1'b1;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stall      = (state_q != StIdle);
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-addressed memory model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        stall, load_valid, access_err, mem_read, mem_write;
   logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] ram [0:63];
   logic [7:0]  refm [0:255];
   logic [31:0] exp_ld;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .RAM_IDX_LSB(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
      .load_data(load_data), .access_err(access_err), .mem_read(mem_read),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous-read RAM with whole-word write.
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_addr[7:2]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [7:0] a);
      return {refm[{a[7:2], 2'd3}], refm[{a[7:2], 2'd2}], refm[{a[7:2], 2'd1}],
              refm[{a[7:2], 2'd0}]};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_lv"}, 32'(load_valid), 32'd0);
      check({tag, "_err"}, 32'(access_err), 32'd0);
      check({tag, "_rd"}, 32'(mem_read), 32'd0);
      check({tag, "_wr"}, 32'(mem_write), 32'd0);
      check({tag, "_addr"}, mem_addr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_ld"}, load_data, 32'd0);
   endtask

   task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [7:0] a, input logic [31:0] wd);
      logic       err, noop, mis;
      logic [7:0] ea, wa, b;
      logic [15:0] h;
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
      noop = !rd && !wr;
      err  = (rd && wr) || (!noop && (sz == 2'd3 || mis));
      ea   = a;
      if (sz == 2'd1) ea[0] = 1'b0;
      else if (sz == 2'd2) ea[1:0] = 2'b00;
      wa = {ea[7:2], 2'b00};

      @(negedge clk);
      req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
      req_unsigned = uns; req_addr = {24'h0, a}; req_wdata = wd;
      #1;
      check("stall_t", 32'(stall), 32'd0);
      if (err || noop) begin
         check("rd_t", 32'(mem_read), 32'd0);
         check("wr_t", 32'(mem_write), 32'd0);
      end else if (rd || sz != 2'd2) begin
         check("rd_t", 32'(mem_read), 32'd1);
         check("wr_t", 32'(mem_write), 32'd0);
         check("addr_t", mem_addr, {24'h0, wa});
      end else begin
         check("rd_t", 32'(mem_read), 32'd0);
         check("wr_t", 32'(mem_write), 32'd1);
         check("addr_t", mem_addr, {24'h0, wa});
         check("wdata_t", mem_wdata, wd);
      end

      @(negedge clk);
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
      check("err_t1", 32'(access_err), 32'(err));
      check("lv_t1", 32'(load_valid), 32'd0);
      if (err || noop) begin
         check("stall_t1", 32'(stall), 32'd0);
      end else if (rd) begin
         check("stall_t1", 32'(stall), 32'd1);
         check("rd_t1", 32'(mem_read), 32'd0);
         check("wr_t1", 32'(mem_write), 32'd0);
         b = refm[ea];
         h = {refm[ea + 8'd1], refm[ea]};
         case (sz)
            2'd0:    exp_ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    exp_ld = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: exp_ld = ref_word(wa);
         endcase
         @(negedge clk);
         check("lv_t2", 32'(load_valid), 32'd1);
         check("stall_t2", 32'(stall), 32'd0);
         check("err_t2", 32'(access_err), 32'd0);
      end else begin
         refm[ea] = wd[7:0];
         if (sz != 2'd0) refm[ea + 8'd1] = wd[15:8];
         if (sz == 2'd2) begin
            refm[ea + 8'd2] = wd[23:16];
            refm[ea + 8'd3] = wd[31:24];
         end
         if (sz == 2'd2) begin
            check("stall_t1", 32'(stall), 32'd0);
         end else begin
            check("stall_t1", 32'(stall), 32'd1);
            check("rmw_wr", 32'(mem_write), 32'd1);
            check("rmw_rd", 32'(mem_read), 32'd0);
            check("rmw_addr", mem_addr, {24'h0, wa});
            check("rmw_wdata", mem_wdata, ref_word(wa));
            @(negedge clk);
            check("stall_t2", 32'(stall), 32'd0);
         end
         check("ram_word", ram[wa[7:2]], ref_word(wa));
      end
      check("ld_hold", load_data, exp_ld);
   endtask

   initial begin
      exp_ld = 32'h0;
      for (int i = 0; i < 256; i++) refm[i] = 8'h00;
      #12;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 64; i++) do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'(i * 4), 32'h0);

      // Reset while an RMW write is pending abandons the write.
      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h10, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h11;
      req_wdata = 32'hAB;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'b0;
      reset = 1'b0;
      #1;
      check_all_zero("rmw_rst");
      @(negedge clk);
      @(negedge clk);
      check("rmw_rst_ram", ram[4], 32'h12345678);
      reset = 1'b1;
      exp_ld = 32'h0;
      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h10, 32'hCAFEF00D);

      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h40, 32'hDEADBEEF);
      do_op(1'b1, 1'b0, 2'd2, 1'b0, 8'h40, 32'h0);
      check("lw40", load_data, 32'hDEADBEEF);

      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h20, 32'h8001F07F);
      do_op(1'b1, 1'b0, 2'd0, 1'b0, 8'h20, 32'h0);
      check("lb20", load_data, 32'h0000007F);
      do_op(1'b1, 1'b0, 2'd0, 1'b0, 8'h23, 32'h0);
      check("lb23", load_data, 32'hFFFFFF80);
      do_op(1'b1, 1'b0, 2'd0, 1'b1, 8'h23, 32'h0);
      check("lbu23", load_data, 32'h00000080);
      do_op(1'b1, 1'b0, 2'd1, 1'b0, 8'h22, 32'h0);
      check("lh22", load_data, 32'hFFFF8001);
      do_op(1'b1, 1'b0, 2'd1, 1'b1, 8'h22, 32'h0);
      check("lhu22", load_data, 32'h00008001);

      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h30, 32'h11223344);
      do_op(1'b0, 1'b1, 2'd0, 1'b0, 8'h31, 32'h000000AA);
      check("sb31", ram[12], 32'h1122AA44);
      do_op(1'b0, 1'b1, 2'd2, 1'b0, 8'h30, 32'h11223344);
      do_op(1'b0, 1'b1, 2'd1, 1'b0, 8'h32, 32'h0000BEEF);
      check("sh32", ram[12], 32'hBEEF3344);

      do_op(1'b1, 1'b1, 2'd2, 1'b0, 8'h40, 32'h55555555);
      do_op(1'b1, 1'b0, 2'd3, 1'b0, 8'h40, 32'h0);
      do_op(1'b0, 1'b1, 2'd3, 1'b0, 8'h40, 32'h0);
      do_op(1'b0, 1'b0, 2'd2, 1'b0, 8'h40, 32'h0);
      do_op(1'b1, 1'b0, 2'd2, 1'b0, 8'h42, 32'h0);
`ifndef MISALIGN_TRAP_EN
      check("lw42", load_data, 32'hDEADBEEF);
`endif

      for (int n = 0; n < 300; n++) begin
         int unsigned kind;
         logic [1:0]  sz;
         kind = $urandom_range(0, 9);
         sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         do_op(kind <= 3 || kind == 8, (kind >= 4 && kind <= 7) || kind == 8, sz,
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
